// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO with a drain FSM that feeds a UART transmitter via a write strobe / busy handshake.
// Define UART_TX_FIFO_OVF_EN to build the sticky overflow flag; otherwise ovf_o is tied low.
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              fifo_wr_i,
  input  logic [7:0]        fifo_dat_i,
  output logic              fifo_full_o,
  output logic              fifo_empty_o,
  output logic [ADDR_W:0]   fifo_level_o,
  input  logic              uart_busy_i,
  output logic              uart_wr_o,
  output logic [7:0]        uart_dat_o,
  input  logic              ovf_clr_i,
  output logic              ovf_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int LVL_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [7:0]         mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    level_q;
  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic               wr_q;
  logic [7:0]         dat_q;

  // Flags come from the registered level, so a push into an empty FIFO shows up one cycle later.
  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // A push while full is dropped even if a pop happens in the same cycle.
  assign push = fifo_wr_i & ~full;
  // A byte leaves the FIFO only once the transmitter has shown it took the strobe.
  assign pop  = (state_q == WAIT_BUSY) & uart_busy_i;

  // NOTE: the storage array has no reset; stale contents are unreachable because level/pointers are reset.
  always_ff @(posedge sys_clk_i) begin
    if (push) begin
      mem[wr_ptr] <= fifo_dat_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // NOTE: next-state gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!empty && !uart_busy_i) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        // No busy one cycle after the strobe means it was missed: resend the same byte.
        state_d = uart_busy_i ? WAIT_DONE : ISSUE;
      end
      WAIT_DONE: begin
        if (!uart_busy_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      dat_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      wr_q    <= (state_d == ISSUE);
      // Data is captured only when leaving IDLE, so retries present the identical byte.
      if (state_q == IDLE && state_d == ISSUE) begin
        dat_q <= mem[rd_ptr];
      end
    end
  end

`ifdef UART_TX_FIFO_OVF_EN
  logic ovf_q;

  // Set has priority over clear so a drop in the clearing cycle is not lost.
  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      ovf_q <= 1'b0;
    end else if (fifo_wr_i && full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr_i) begin
      ovf_q <= 1'b0;
    end
  end

  assign ovf_o = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr_i;
  assign ovf_o          = 1'b0;
`endif

  assign fifo_full_o  = full;
  assign fifo_empty_o = empty;
  assign fifo_level_o = level_q;
  assign uart_wr_o    = wr_q;
  assign uart_dat_o   = dat_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo with a transmitter model that raises busy
// one cycle after an accepted strobe; compares the emitted byte stream against the pushed one.
module tb_uart_tx_fifo;

`ifdef UART_TX_FIFO_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic       sys_clk_i;
  logic       sys_rst_i;
  logic       fifo_wr_i;
  logic [7:0] fifo_dat_i;
  logic       fifo_full_o;
  logic       fifo_empty_o;
  logic [4:0] fifo_level_o;
  logic       uart_busy_i;
  logic       uart_wr_o;
  logic [7:0] uart_dat_o;
  logic       ovf_clr_i;
  logic       ovf_o;

  uart_tx_fifo #(.ADDR_W(4)) dut (
    .sys_clk_i    (sys_clk_i),
    .sys_rst_i    (sys_rst_i),
    .fifo_wr_i    (fifo_wr_i),
    .fifo_dat_i   (fifo_dat_i),
    .fifo_full_o  (fifo_full_o),
    .fifo_empty_o (fifo_empty_o),
    .fifo_level_o (fifo_level_o),
    .uart_busy_i  (uart_busy_i),
    .uart_wr_o    (uart_wr_o),
    .uart_dat_o   (uart_dat_o),
    .ovf_clr_i    (ovf_clr_i),
    .ovf_o        (ovf_o)
  );

  initial begin
    sys_clk_i = 1'b0;
    forever #5 sys_clk_i = ~sys_clk_i;
  end

  // Transmitter model: takes a strobe (unless told to ignore it), then holds busy for busy_len cycles.
  logic       force_busy = 1'b0;
  logic       busy_m     = 1'b0;
  int         busy_cnt   = 0;
  int         busy_len   = 3;
  logic       rand_len   = 1'b0;
  int         strobe_cnt = 0;
  int         ignore_idx = -1;
  logic [7:0] rx_q[$];
  int         rx_rd      = 0;

  assign uart_busy_i = force_busy | busy_m;

  always @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      busy_m   <= 1'b0;
      busy_cnt <= 0;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) busy_m <= 1'b0;
    end else if (uart_wr_o) begin
      strobe_cnt <= strobe_cnt + 1;
      if (strobe_cnt != ignore_idx) begin
        busy_m   <= 1'b1;
        busy_cnt <= rand_len ? int'($urandom_range(6, 1)) : busy_len;
        rx_q.push_back(uart_dat_o);
      end
    end
  end

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];

  typedef struct packed {
    logic       wr;
    logic [7:0] dat;
    logic       clr;
    logic       acc;
    logic [4:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic cycle();
    @(posedge sys_clk_i);
    @(negedge sys_clk_i);
  endtask

  task automatic wait_strobe(input string tag);
    int n = 0;
    while (!uart_wr_o && n < 20) begin
      cycle();
      n++;
    end
    check({tag, "_strobe_seen"}, uart_wr_o, 1);
  endtask

  task automatic wait_drain(input string tag);
    int n     = 0;
    int quiet = 0;
    while (quiet < 3 && n < 2000) begin
      cycle();
      n++;
      if (fifo_empty_o && !uart_busy_i && !uart_wr_o) quiet++;
      else quiet = 0;
    end
    check({tag, "_drained"}, quiet >= 3, 1);
  endtask

  task automatic compare_stream(input string tag);
    int got = rx_q.size() - rx_rd;
    check({tag, "_count"}, got, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got) check($sformatf("%s_byte%0d", tag, i), rx_q[rx_rd + i], exp_q[i]);
    end
    rx_rd = rx_q.size();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] b;
    int         sent;
    int         guard;
    logic       saw_wr;

    sys_rst_i  = 1'b1;
    fifo_wr_i  = 1'b0;
    fifo_dat_i = 8'h00;
    ovf_clr_i  = 1'b0;
    repeat (2) @(negedge sys_clk_i);
    check("init_flags", {fifo_level_o, fifo_full_o, fifo_empty_o}, {5'd0, 1'b0, 1'b1});
    check("init_out", {uart_wr_o, uart_dat_o, ovf_o}, 10'h0);
    sys_rst_i = 1'b0;
    cycle();

    // Single byte: strobe exactly in cycle N+2, pop when busy is seen.
    busy_len = 3;
    exp_q.push_back(8'h55);
    fifo_wr_i = 1'b1; fifo_dat_i = 8'h55;
    cycle();
    fifo_wr_i = 1'b0;
    check("t2_n_wr", uart_wr_o, 0);
    check("t2_n_empty", fifo_empty_o, 0);
    check("t2_n_level", fifo_level_o, 1);
    cycle();
    check("t2_n1_wr", uart_wr_o, 1);
    check("t2_n1_dat", uart_dat_o, 8'h55);
    cycle();
    check("t2_n2_wr", uart_wr_o, 0);
    check("t2_n2_busy", uart_busy_i, 1);
    check("t2_n2_level", fifo_level_o, 1);
    check("t2_n2_dat_hold", uart_dat_o, 8'h55);
    cycle();
    check("t2_n3_level", fifo_level_o, 0);
    check("t2_n3_wr", uart_wr_o, 0);
    wait_drain("t2");
    compare_stream("t2");

    // Lost strobe: first strobe ignored, same byte re-strobed, no pop until busy.
    ignore_idx = strobe_cnt;
    exp_q.push_back(8'h3C);
    fifo_wr_i = 1'b1; fifo_dat_i = 8'h3C;
    cycle();
    fifo_wr_i = 1'b0;
    cycle();
    check("t4_first_wr", {uart_wr_o, uart_dat_o}, {1'b1, 8'h3C});
    cycle();
    check("t4_lost", {uart_wr_o, uart_busy_i, fifo_level_o}, {1'b0, 1'b0, 5'd1});
    cycle();
    check("t4_retry_wr", {uart_wr_o, uart_dat_o, fifo_level_o}, {1'b1, 8'h3C, 5'd1});
    cycle();
    check("t4_taken", {uart_wr_o, uart_busy_i, fifo_level_o}, {1'b0, 1'b1, 5'd1});
    cycle();
    check("t4_popped", fifo_level_o, 0);
    wait_drain("t4");
    compare_stream("t4");

    // Overflow table: transmitter held busy so nothing drains.
    for (int i = 0; i < 16; i++) begin
      vecs[i] = '{1'b1, 8'(i), 1'b0, 1'b1, 5'(i + 1), (i == 15), 1'b0, 1'b0};
    end
    vecs[16] = '{1'b1, 8'hAA, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, OVF_ON};
    vecs[17] = '{1'b1, 8'hAB, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, OVF_ON};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 8'h00, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 1'b0};
    force_busy = 1'b1;
    for (int i = 0; i < 20; i++) begin
      fifo_wr_i  = vecs[i].wr;
      fifo_dat_i = vecs[i].dat;
      ovf_clr_i  = vecs[i].clr;
      if (vecs[i].acc) exp_q.push_back(vecs[i].dat);
      cycle();
      check($sformatf("t3_row%0d", i),
            {fifo_level_o, fifo_full_o, fifo_empty_o, ovf_o, uart_wr_o},
            {vecs[i].lvl, vecs[i].full, vecs[i].empty, vecs[i].ovf, 1'b0});
    end
    fifo_wr_i = 1'b0;
    ovf_clr_i = 1'b0;
    // Push in the very cycle a pop happens while full: still dropped.
    force_busy = 1'b0;
    wait_strobe("t3");
    cycle();
    check("t3_full_at_pop", {fifo_full_o, uart_busy_i}, 2'b11);
    fifo_wr_i = 1'b1; fifo_dat_i = 8'hEE;
    cycle();
    fifo_wr_i = 1'b0;
    check("t3_no_rescue_level", fifo_level_o, 15);
    check("t3_no_rescue_ovf", ovf_o, OVF_ON);
    wait_drain("t3");
    compare_stream("t3");

    // Concurrent push/pop at level 5.
    busy_len   = 2;
    force_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      fifo_wr_i = 1'b1; fifo_dat_i = 8'(8'h11 + i);
      exp_q.push_back(8'(8'h11 + i));
      cycle();
    end
    fifo_wr_i  = 1'b0;
    force_busy = 1'b0;
    wait_strobe("t5");
    cycle();
    check("t5_pre_level", {fifo_level_o, uart_busy_i}, {5'd5, 1'b1});
    fifo_wr_i = 1'b1; fifo_dat_i = 8'h16;
    exp_q.push_back(8'h16);
    cycle();
    fifo_wr_i = 1'b0;
    check("t5_pushpop_level", fifo_level_o, 5);
    wait_drain("t5");
    compare_stream("t5");

    // Random stream across pointer wrap with random busy length.
    rand_len = 1'b1;
    sent     = 0;
    guard    = 0;
    while (sent < 40 && guard < 2000) begin
      guard++;
      if (!fifo_full_o && $urandom_range(3, 0) != 0) begin
        b          = 8'($urandom);
        fifo_wr_i  = 1'b1;
        fifo_dat_i = b;
        exp_q.push_back(b);
        sent++;
      end else begin
        fifo_wr_i = 1'b0;
      end
      cycle();
    end
    fifo_wr_i = 1'b0;
    check("t6_sent", sent, 40);
    wait_drain("t6");
    compare_stream("t6");
    rand_len = 1'b0;

    // Asynchronous reset mid-frame with a full, overflowed FIFO.
    busy_len   = 8;
    force_busy = 1'b1;
    for (int i = 0; i < 17; i++) begin
      fifo_wr_i = 1'b1; fifo_dat_i = 8'(8'hC0 + i);
      cycle();
    end
    fifo_wr_i  = 1'b0;
    force_busy = 1'b0;
    wait_strobe("t1");
    cycle();
    cycle();
    check("t1_pre_state", {fifo_level_o, uart_busy_i, ovf_o}, {5'd15, 1'b1, OVF_ON});
    #2 sys_rst_i = 1'b1;
    #1;
    check("t1_rst_flags", {fifo_level_o, fifo_full_o, fifo_empty_o}, {5'd0, 1'b0, 1'b1});
    check("t1_rst_wr", uart_wr_o, 0);
    check("t1_rst_dat", uart_dat_o, 8'h00);
    check("t1_rst_ovf", ovf_o, 0);
    @(negedge sys_clk_i);
    sys_rst_i = 1'b0;
    saw_wr    = 1'b0;
    repeat (6) begin
      cycle();
      if (uart_wr_o) saw_wr = 1'b1;
    end
    check("t1_discarded", {saw_wr, fifo_level_o, fifo_empty_o}, {1'b0, 5'd0, 1'b1});
    rx_rd = rx_q.size();
    exp_q.delete();
    busy_len = 2;
    exp_q.push_back(8'h99);
    fifo_wr_i = 1'b1; fifo_dat_i = 8'h99;
    cycle();
    fifo_wr_i = 1'b0;
    wait_drain("t1_post");
    compare_stream("t1_post");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
